// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the 8-bit data / 16-bit address memory bus between the
// CPU and the DMA/video requester. The grant is registered and ties are broken
// round-robin. One dead cycle is forced between owners, and the DMA hold time
// is bounded while the CPU is waiting.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r,
    input  logic        cpu_w,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_r,
    input  logic        dma_w,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic [15:0] adress_bus,
    output logic        r,
    output logic        w,
    output logic [7:0]  wdata,
    output logic        drive,
    output logic        rw_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2,
        S_TURN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic             last_dma;   // 1 when DMA held the most recent grant
    logic [CNT_W-1:0] hold_cnt;

    logic             pick_cpu_c;
    logic             pick_dma_c;
    logic             own_r_c;
    logic             own_w_c;

    // Round-robin choice used from IDLE and TURN
    always_comb begin
        pick_cpu_c = cpu_req && (!dma_req || last_dma);
        pick_dma_c = dma_req && (!cpu_req || !last_dma);
    end

    // Bus mux: an owner that has dropped its request drives nothing
    always_comb begin
        adress_bus = 16'h0000;
        wdata      = 8'h00;
        own_r_c    = 1'b0;
        own_w_c    = 1'b0;
        if (cpu_gnt && cpu_req) begin
            adress_bus = cpu_addr;
            wdata      = cpu_wdata;
            own_r_c    = cpu_r;
            own_w_c    = cpu_w;
        end else if (dma_gnt && dma_req) begin
            adress_bus = dma_addr;
            wdata      = dma_wdata;
            own_r_c    = dma_r;
            own_w_c    = dma_w;
        end
        r     = own_r_c;
        w     = own_w_c & ~own_r_c;
        drive = own_w_c & ~own_r_c;
    end

    // Grant FSM with registered grants, hold counter and sticky r/w conflict flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            last_dma <= 1'b1;
            hold_cnt <= '0;
            rw_err   <= 1'b0;
        end else begin
            if (own_r_c && own_w_c) begin
                rw_err <= 1'b1;
            end
            case (state)
                S_IDLE, S_TURN: begin
                    if (pick_cpu_c) begin
                        state    <= S_CPU;
                        cpu_gnt  <= 1'b1;
                        dma_gnt  <= 1'b0;
                        last_dma <= 1'b0;
                    end else if (pick_dma_c) begin
                        state    <= S_DMA;
                        cpu_gnt  <= 1'b0;
                        dma_gnt  <= 1'b1;
                        last_dma <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state   <= S_IDLE;
                        cpu_gnt <= 1'b0;
                        dma_gnt <= 1'b0;
                    end
                end
                S_CPU: begin
                    if (!cpu_req) begin
                        state   <= S_TURN;
                        cpu_gnt <= 1'b0;
                    end
                end
                S_DMA: begin
                    if (!dma_req) begin
                        state    <= S_TURN;
                        dma_gnt  <= 1'b0;
                        hold_cnt <= '0;
                    end else if (cpu_req) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= S_TURN;
                            dma_gnt  <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                end
            endcase
        end
    end

    // Both grants are never active at the same time
    a_gnt_onehot: assert property (@(posedge clk) !(cpu_gnt && dma_gnt));

endmodule
